// File: rtl/mul_pkg.sv
// Shared helpers for the FP multiplier datapath: exponent bias and limit,
// plus the popcount and saturating-add used by the optional statistics counters.
package mul_pkg;

  function automatic int expo_bias(input int expo_w);
    return (1 << (expo_w - 1)) - 1;
  endfunction

  function automatic int expo_max(input int expo_w);
    return (1 << expo_w) - 1;
  endfunction

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] c, input int inc);
    int s;
    s = int'(c) + inc;
    return (s > 16'hFFFF) ? 16'hFFFF : 16'(s);
  endfunction

endpackage

// File: rtl/mul_expo_lane.sv
// One lane of the sign/exponent stage: effective exponent select and biased sum,
// plus overflow/underflow flags derived from the registered first-stage exponent.
module mul_expo_lane
  import mul_pkg::*;
#(
  parameter int EXPO_W = 8
) (
  input  logic                     i_a_sign,
  input  logic                     i_b_sign,
  input  logic                     i_a_is_sub,
  input  logic                     i_b_is_sub,
  input  logic [EXPO_W-1:0]        i_a_expo,
  input  logic [EXPO_W-1:0]        i_b_expo,
  output logic                     o_sign,
  output logic signed [EXPO_W+1:0] o_expo,
  input  logic signed [EXPO_W+1:0] i_s1_expo,
  output logic                     o_ovf,
  output logic                     o_udf
);

  localparam int XW = EXPO_W + 2;
  localparam logic signed [XW-1:0] BIAS = XW'(expo_bias(EXPO_W));
  localparam logic signed [XW-1:0] EMAX = XW'(expo_max(EXPO_W));
  localparam logic signed [XW-1:0] ZERO = '0;
  localparam logic signed [XW-1:0] ONE  = XW'(1);

  logic signed [XW-1:0] w_ea;
  logic signed [XW-1:0] w_eb;

  // Subnormals carry an effective exponent of 1 regardless of the field.
  assign w_ea   = i_a_is_sub ? ONE : $signed({2'b00, i_a_expo});
  assign w_eb   = i_b_is_sub ? ONE : $signed({2'b00, i_b_expo});
  assign o_sign = i_a_sign ^ i_b_sign;
  assign o_expo = w_ea + w_eb - BIAS;

  assign o_ovf  = (i_s1_expo >= EMAX);
  assign o_udf  = (i_s1_expo <= ZERO);

endmodule

// File: rtl/mul_expo_pipe.sv
// Two-stage pipelined sign/exponent stage with valid/ready handshake and tag passthrough.
// Optional 16-bit saturating ovf/udf counters when MUL_EXPO_PIPE_STAT_EN is defined.
module mul_expo_pipe
  import mul_pkg::*;
#(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int LANES  = 1,
  parameter int TAG_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [TAG_W-1:0]              in_tag,
  input  logic [LANES-1:0]              a_sign,
  input  logic [LANES-1:0]              b_sign,
  input  logic [LANES-1:0]              a_is_sub,
  input  logic [LANES-1:0]              b_is_sub,
  input  logic [LANES*EXPO_W-1:0]       a_expo,
  input  logic [LANES*EXPO_W-1:0]       b_expo,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TAG_W-1:0]              out_tag,
  output logic [LANES-1:0]              sign_o,
  output logic [LANES*(EXPO_W+2)-1:0]   expo_o,
  output logic [LANES-1:0]              ovf_o,
  output logic [LANES-1:0]              udf_o
`ifdef MUL_EXPO_PIPE_STAT_EN
  ,
  output logic [15:0]                   ovf_cnt,
  output logic [15:0]                   udf_cnt
`endif
);

  localparam int XW = EXPO_W + 2;

  typedef struct packed {
    logic          sign;
    logic [XW-1:0] expo;
  } s1_lane_t;

  // Mantissa width travels with the datapath family but has no role here.
  if (MANT_W < 1 || TAG_W < 1) begin : g_param_invalid
  end

  logic                    r_s1_v;
  logic                    r_s2_v;
  logic [TAG_W-1:0]        r_s1_tag;
  logic [TAG_W-1:0]        r_s2_tag;
  s1_lane_t [LANES-1:0]    w_s1_d;
  s1_lane_t [LANES-1:0]    r_s1;
  s1_lane_t [LANES-1:0]    r_s2;
  logic [LANES-1:0]        w_ovf;
  logic [LANES-1:0]        w_udf;
  logic [LANES-1:0]        r_s2_ovf;
  logic [LANES-1:0]        r_s2_udf;
  logic                    w_s1_adv;
  logic                    w_s2_adv;

  // Each stage advances when empty or when its successor advances; bubbles collapse.
  assign w_s2_adv  = !r_s2_v || out_ready;
  assign w_s1_adv  = !r_s1_v || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_v;
  assign out_tag   = r_s2_tag;
  assign ovf_o     = r_s2_ovf;
  assign udf_o     = r_s2_udf;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mul_expo_lane #(
      .EXPO_W (EXPO_W)
    ) u_lane (
      .i_a_sign   (a_sign[i]),
      .i_b_sign   (b_sign[i]),
      .i_a_is_sub (a_is_sub[i]),
      .i_b_is_sub (b_is_sub[i]),
      .i_a_expo   (a_expo[i*EXPO_W +: EXPO_W]),
      .i_b_expo   (b_expo[i*EXPO_W +: EXPO_W]),
      .o_sign     (w_s1_d[i].sign),
      .o_expo     (w_s1_d[i].expo),
      .i_s1_expo  (r_s1[i].expo),
      .o_ovf      (w_ovf[i]),
      .o_udf      (w_udf[i])
    );

    assign sign_o[i]           = r_s2[i].sign;
    assign expo_o[i*XW +: XW]  = r_s2[i].expo;
  end

  // NOTE: data registers are reset as well because the outputs must read zero
  // after reset; they load on stage advance only, never gated by the valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v   <= 1'b0;
      r_s2_v   <= 1'b0;
      r_s1_tag <= '0;
      r_s2_tag <= '0;
      r_s1     <= '0;
      r_s2     <= '0;
      r_s2_ovf <= '0;
      r_s2_udf <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_v   <= in_valid;
        r_s1_tag <= in_tag;
        r_s1     <= w_s1_d;
      end
      if (w_s2_adv) begin
        r_s2_v   <= r_s1_v;
        r_s2_tag <= r_s1_tag;
        r_s2     <= r_s1;
        r_s2_ovf <= w_ovf;
        r_s2_udf <= w_udf;
      end
    end
  end

`ifdef MUL_EXPO_PIPE_STAT_EN
  logic [15:0] r_ovf_cnt;
  logic [15:0] r_udf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_cnt <= '0;
      r_udf_cnt <= '0;
    end else if (r_s2_v && out_ready) begin
      r_ovf_cnt <= sat_add16(r_ovf_cnt, popcount(32'(r_s2_ovf)));
      r_udf_cnt <= sat_add16(r_udf_cnt, popcount(32'(r_s2_udf)));
    end
  end

  assign ovf_cnt = r_ovf_cnt;
  assign udf_cnt = r_udf_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
